// File: rtl/axi_man_csr_if.sv
// Single-beat AXI manager for CSR subordinates: command/response front end,
// one outstanding AW/W/B or AR/R transaction, with an optional per-transaction timeout.
module axi_man_csr_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  m_axi_clk,
  input  logic                  m_axi_resetn,
  // command / response side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  // write channels
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic                  m_axi_wlast,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  // read channels
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast
);

  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;
  logic                  rsp_timeout_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic [CNT_W-1:0]      tmo_cnt_q;
  logic [CNT_W-1:0]      tmo_cnt_d;

  logic aw_done;
  logic w_done;
  logic busy;
  logic hs_done;
  logic tmo_fire;
  logic abort;

  // A handshake completing in the same cycle as the timeout takes priority.
  always_comb begin
    aw_done  = aw_done_q | (awvalid_q & m_axi_awready);
    w_done   = w_done_q  | (wvalid_q  & m_axi_wready);
    busy     = (state_q == WR_REQ) || (state_q == WR_RESP) ||
               (state_q == RD_REQ) || (state_q == RD_DATA);
    hs_done  = 1'b0;
    case (state_q)
      WR_REQ:  hs_done = aw_done & w_done;
      WR_RESP: hs_done = m_axi_bvalid;
      RD_REQ:  hs_done = m_axi_arready;
      RD_DATA: hs_done = m_axi_rvalid;
      default: hs_done = 1'b0;
    endcase
    tmo_fire = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q >= TO_LAST);
    abort    = busy && tmo_fire && !hs_done;
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == IDLE) && cmd_valid) begin
      tmo_cnt_d = '0;
    end else if (busy && (tmo_cnt_q != {CNT_W{1'b1}})) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge m_axi_clk or negedge m_axi_resetn) begin
    if (!m_axi_resetn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_ff @(posedge m_axi_clk or negedge m_axi_resetn) begin
    if (!m_axi_resetn) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q        <= cmd_addr;
            wdata_q       <= cmd_wdata;
            cmd_ready_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W retire independently; the B phase starts once both have.
          if (awvalid_q && m_axi_awready) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (wvalid_q && m_axi_wready) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m_axi_bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end

        RD_REQ: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= m_axi_rdata;
            rsp_resp_q  <= m_axi_rlast ? m_axi_rresp : RESP_SLVERR;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase

      if (abort) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        bready_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        rready_q      <= 1'b0;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= RESP_SLVERR;
        rsp_timeout_q <= 1'b1;
        rsp_valid_q   <= 1'b1;
        state_q       <= RESP;
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wlast   = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_man_csr_if.sv
// Directed bench for axi_man_csr_if: a configurable reactive subordinate plus
// per-scenario tasks with hand-computed expectations.
module tb_axi_man_csr_if;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic          awvalid, awready, wvalid, wready, wlast;
  logic          bvalid, bready, arvalid, arready, rvalid, rready, rlast;
  logic [1:0]    bresp, rresp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_man_csr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .m_axi_clk(clk), .m_axi_resetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_wlast(wlast), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_bresp(bresp), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast)
  );

  // Subordinate: ready after a programmable number of valid cycles, B/R one cycle after request.
  int         aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic       b_stall = 1'b0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [7:0] rdata_cfg = 8'h00;
  logic       rlast_cfg = 1'b1;
  int         aw_cnt, w_cnt, ar_cnt;
  logic       aw_seen, w_seen, bvalid_r, rvalid_r;
  logic       aw_now, w_now;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid && (ar_cnt >= ar_delay);
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_cfg;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_cfg;
  assign rresp   = rresp_cfg;
  assign rlast   = rlast_cfg;
  assign aw_now  = aw_seen || (awvalid && awready);
  assign w_now   = w_seen || (wvalid && wready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (bvalid_r && bready) begin
        bvalid_r <= 1'b0;
        aw_seen  <= aw_now;
        w_seen   <= w_now;
      end else if (!bvalid_r && aw_now && w_now && !b_stall) begin
        bvalid_r <= 1'b1;
        aw_seen  <= 1'b0;
        w_seen   <= 1'b0;
      end else begin
        aw_seen <= aw_now;
        w_seen  <= w_now;
      end
      if (rvalid_r && rready) rvalid_r <= 1'b0;
      else if (!rvalid_r && arvalid && arready) rvalid_r <= 1'b1;
    end
  end

  // Channel activity monitors; scenarios compare deltas across a transaction.
  int            aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_hs = 0, unstable = 0;
  logic          prev_awv = 1'b0;
  logic [AW-1:0] prev_awaddr = '0;
  always @(posedge clk) begin
    if (awvalid) aw_cyc <= aw_cyc + 1;
    if (wvalid)  w_cyc  <= w_cyc + 1;
    if (arvalid) ar_cyc <= ar_cyc + 1;
    if (bvalid && bready) b_hs <= b_hs + 1;
    if (awvalid && prev_awv && (awaddr != prev_awaddr)) unstable <= unstable + 1;
    prev_awv    <= awvalid;
    prev_awaddr <= awaddr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns once it has been accepted (now in cycle 1).
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      step();
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL issue_accept: cmd_ready never seen for addr %h", a);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, wlast} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 10000000",
               {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, wlast});
    end
    checks++;
    if ({awaddr, araddr, wdata, rsp_rdata, rsp_resp, rsp_timeout} !== 35'd0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {awaddr, araddr, wdata, rsp_rdata, rsp_resp, rsp_timeout});
    end
    rst_n = 1'b1;
    step(); step();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: cmd_ready,rsp_valid=%b want 10", {cmd_ready, rsp_valid});
    end
    $display("test_reset done");
  endtask

  task automatic test_write_basic();
    int lat, aw0, w0, b0;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs;
    issue(1'b1, 8'h00, 8'h01);
    checks++;
    if ({awvalid, wvalid, wlast, cmd_ready} !== 4'b1110 || awaddr !== 8'h00 || wdata !== 8'h01) begin
      failures++;
      $display("FAIL wr_req: aw,w,wlast,cmd_ready=%b addr=%h data=%h want 1110 00 01",
               {awvalid, wvalid, wlast, cmd_ready}, awaddr, wdata);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL wr_latency: got %0d want 3", lat); end
    checks++;
    if ({rsp_resp, rsp_timeout, rsp_rdata} !== 11'd0) begin
      failures++;
      $display("FAIL wr_rsp: resp=%b to=%b rdata=%h want 00 0 00", rsp_resp, rsp_timeout, rsp_rdata);
    end
    checks++;
    if (aw_cyc - aw0 != 1 || w_cyc - w0 != 1 || b_hs - b0 != 1) begin
      failures++;
      $display("FAIL wr_beats: aw=%0d w=%0d b=%0d want 1 1 1", aw_cyc - aw0, w_cyc - w0, b_hs - b0);
    end
    consume();
    $display("test_write_basic lat=%0d resp=%b", lat, rsp_resp);
  endtask

  task automatic test_read_block();
    int lat;
    bit blocked_ok;
    rdata_cfg = 8'h02;
    issue(1'b0, 8'h01, 8'h00);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 8'h01) begin
      failures++;
      $display("FAIL rd_req: arvalid=%b araddr=%h want 1 01", arvalid, araddr);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_rdata !== 8'h02 || rsp_resp !== 2'b00) begin
      failures++;
      $display("FAIL rd_rsp: lat=%0d rdata=%h resp=%b want 3 02 00", lat, rsp_rdata, rsp_resp);
    end
    blocked_ok = 1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 8'h02) blocked_ok = 0;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!blocked_ok) begin
      failures++;
      $display("FAIL rd_block: cmd_ready=%b rsp_valid=%b rdata=%h want 0 1 02", cmd_ready, rsp_valid, rsp_rdata);
    end
    consume();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL rd_release: cmd_ready,rsp_valid=%b want 10", {cmd_ready, rsp_valid});
    end
    $display("test_read_block lat=%0d rdata=%h", lat, 8'h02);
  endtask

  task automatic test_aw_delay();
    int lat, aw0, w0, b0, u0;
    aw_delay = 4;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs; u0 = unstable;
    issue(1'b1, 8'h3C, 8'hA5);
    wait_rsp(lat);
    checks++;
    if (lat != 7 || rsp_resp !== 2'b00) begin
      failures++;
      $display("FAIL awdly_rsp: lat=%0d resp=%b want 7 00", lat, rsp_resp);
    end
    consume();
    step();
    checks++;
    if (aw_cyc - aw0 != 5 || w_cyc - w0 != 1) begin
      failures++;
      $display("FAIL awdly_valid: aw=%0d w=%0d want 5 1", aw_cyc - aw0, w_cyc - w0);
    end
    checks++;
    if (unstable != u0 || b_hs - b0 != 1) begin
      failures++;
      $display("FAIL awdly_stable: addr_changes=%0d b=%0d want 0 1", unstable - u0, b_hs - b0);
    end
    aw_delay = 0;
    $display("test_aw_delay lat=%0d", lat);
  endtask

  task automatic test_timeout();
    int lat, ar0;
    ar_delay = 1000;
    ar0 = ar_cyc;
    issue(1'b0, 8'h10, 8'h00);
    wait_rsp(lat);
    checks++;
    if (lat != 9 || ar_cyc - ar0 != 8) begin
      failures++;
      $display("FAIL tmo_timing: lat=%0d ar_cycles=%0d want 9 8", lat, ar_cyc - ar0);
    end
    checks++;
    if ({rsp_resp, rsp_timeout, arvalid, rready} !== 5'b10100) begin
      failures++;
      $display("FAIL tmo_rsp: resp,to,arv,rrdy=%b want 10100", {rsp_resp, rsp_timeout, arvalid, rready});
    end
    consume();
    checks++;
    if (rsp_timeout !== 1'b1) begin
      failures++;
      $display("FAIL tmo_hold: rsp_timeout=%b want 1", rsp_timeout);
    end
    ar_delay = 0;
    issue(1'b1, 8'h11, 8'h22);
    checks++;
    if (rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear: rsp_timeout=%b want 0", rsp_timeout);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_timeout !== 1'b0 || rsp_resp !== 2'b00) begin
      failures++;
      $display("FAIL tmo_next: lat=%0d to=%b resp=%b want 3 0 00", lat, rsp_timeout, rsp_resp);
    end
    consume();
    $display("test_timeout done");
  endtask

  task automatic test_timeout_boundary();
    int lat;
    ar_delay = 7;
    rdata_cfg = 8'h5A;
    issue(1'b0, 8'h20, 8'h00);
    wait_rsp(lat);
    checks++;
    if (lat != 10 || rsp_timeout !== 1'b0 || rsp_resp !== 2'b00 || rsp_rdata !== 8'h5A) begin
      failures++;
      $display("FAIL tmo_edge: lat=%0d to=%b resp=%b rdata=%h want 10 0 00 5a",
               lat, rsp_timeout, rsp_resp, rsp_rdata);
    end
    consume();
    ar_delay = 0;
    $display("test_timeout_boundary lat=%0d", lat);
  endtask

  task automatic test_resp_codes();
    int lat;
    rlast_cfg = 1'b0;
    rdata_cfg = 8'h77;
    issue(1'b0, 8'h30, 8'h00);
    wait_rsp(lat);
    checks++;
    if (rsp_resp !== 2'b10 || rsp_rdata !== 8'h77 || rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rlast0: resp=%b rdata=%h to=%b want 10 77 0", rsp_resp, rsp_rdata, rsp_timeout);
    end
    consume();
    rlast_cfg = 1'b1;
    bresp_cfg = 2'b11;
    issue(1'b1, 8'h31, 8'h44);
    wait_rsp(lat);
    checks++;
    if (rsp_resp !== 2'b11 || rsp_rdata !== 8'h00 || lat != 3) begin
      failures++;
      $display("FAIL bresp3: resp=%b rdata=%h lat=%0d want 11 00 3", rsp_resp, rsp_rdata, lat);
    end
    consume();
    bresp_cfg = 2'b00;
    $display("test_resp_codes done");
  endtask

  task automatic test_reset_mid();
    int b0;
    bit saw_rsp;
    b_stall = 1'b1;
    b0 = b_hs;
    issue(1'b1, 8'h40, 8'h99);
    step();
    checks++;
    if (bready !== 1'b1 || awvalid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre: bready=%b awvalid=%b want 1 0", bready, awvalid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 7'b1000000 || awaddr !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_async: ctrl=%b addr=%h want 1000000 00",
               {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, awaddr);
    end
    step(); step();
    rst_n = 1'b1;
    b_stall = 1'b0;
    saw_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid !== 1'b0) saw_rsp = 1;
    end
    checks++;
    if (saw_rsp || cmd_ready !== 1'b1 || b_hs != b0) begin
      failures++;
      $display("FAIL rstmid_post: saw_rsp=%0d cmd_ready=%b b=%0d want 0 1 0", saw_rsp, cmd_ready, b_hs - b0);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_block();
    test_aw_delay();
    test_timeout();
    test_timeout_boundary();
    test_resp_codes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
